// File: rtl/galaksija_tape_pkg.sv
// galaksija_tape_pkg
// Shared definitions for the cassette playback sequencer: FSM state type,
// bit-cell geometry, default timing, and the slot-to-level mapping used by
// the bit generator.
package galaksija_tape_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEADER,
    FETCH,
    LOAD,
    PLAY,
    GAP
  } tape_state_t;

  localparam int unsigned SLOTS_PER_BIT = 8;
  localparam int unsigned SYNC_SLOT     = 0;
  localparam int unsigned DATA_SLOT     = 4;

  localparam int unsigned DEF_SLOT_CYCLES  = 1151;
  localparam int unsigned DEF_GAP_CYCLES   = 13001;
  localparam int unsigned DEF_LEADER_BYTES = 96;

  // Tape level for one slot of a bit cell: low for the sync slot, low in the
  // data slot for a '1', high everywhere else.
  function automatic logic cell_level(input logic [2:0] slot, input logic data_bit);
    return !((slot == 3'(SYNC_SLOT)) || ((slot == 3'(DATA_SLOT)) && data_bit));
  endfunction

endpackage

// File: rtl/galaksija_tape_bitgen.sv
// galaksija_tape_bitgen
// Serialises one byte LSB-first into Galaksija pulse-coded bit cells and
// times the inter-byte gap.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - abandon the current byte, force tape_bit high
//   load        - capture byte_in, zero timer/slot/bit counters
//   byte_in     - byte to serialise
//   tick_en     - throttle; timer advances only when high
//   play, gap   - sequencer is in a bit-cell phase / in the gap slot
//   byte_end    - strobe: slot 6 of bit 7 expires (gap slot follows)
//   gap_end     - strobe: gap slot expires
//   tape_bit    - registered serial tape level, idle high
module galaksija_tape_bitgen
  import galaksija_tape_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES = DEF_SLOT_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] byte_in,
  input  logic       tick_en,
  input  logic       play,
  input  logic       gap,
  output logic       byte_end,
  output logic       gap_end,
  output logic       tape_bit
);

  localparam int unsigned TIMER_MAX = (GAP_CYCLES > SLOT_CYCLES) ? GAP_CYCLES : SLOT_CYCLES;
  localparam int unsigned TIMER_W   = $clog2(TIMER_MAX);

  logic [TIMER_W-1:0] timer;
  logic [2:0]         slot;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_byte;
  logic               slot_wrap;

  assign slot_wrap = play && tick_en && (timer == TIMER_W'(SLOT_CYCLES - 1));
  // The eighth slot of bit 7 is the gap, timed separately by the sequencer.
  assign byte_end  = slot_wrap && (bit_idx == 3'd7) && (slot == 3'(SLOTS_PER_BIT - 2));
  assign gap_end   = gap && tick_en && (timer == TIMER_W'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer      <= '0;
      slot       <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      tape_bit   <= 1'b1;
    end else if (load || clear) begin
      timer    <= '0;
      slot     <= '0;
      bit_idx  <= '0;
      tape_bit <= 1'b1;
      if (load) shift_byte <= byte_in;
    end else begin
      // Level follows the frozen slot while throttled, so it holds too.
      tape_bit <= play ? cell_level(slot, shift_byte[0]) : 1'b1;
      if (play && tick_en) begin
        if (slot_wrap) begin
          timer <= '0;
          slot  <= slot + 1'b1;
          if (slot == 3'(SLOTS_PER_BIT - 1)) begin
            bit_idx    <= bit_idx + 1'b1;
            shift_byte <= {1'b0, shift_byte[7:1]};
          end
        end else begin
          timer <= timer + 1'b1;
        end
      end else if (gap && tick_en) begin
        timer <= gap_end ? '0 : timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/galaksija_tape_player.sv
// galaksija_tape_player
// Cassette playback sequencer: walks the tape buffer from address 0 to the
// programmed last address, fetching each byte over a 1-cycle-latency read
// port and handing it to the bit generator.
// Optional: define TAPE_LEADER_EN to precede the data with LEADER_BYTES
// bytes of 0x00 (no RAM reads during the leader).
// Ports:
//   clk, reset  - cpuclk, asynchronous active-high reset
//   start       - pulse: (re)start playback at address 0, sample last_addr
//   abort       - pulse: stop playback (wins over start)
//   tick_en     - throttle for all slot/gap timing
//   last_addr   - last buffer address played, inclusive
//   rd_addr     - buffer read address; rd_data valid one cycle later
//   rd_data     - buffer read data
//   tape_bit    - serial tape level, idle high
//   active      - high while playing
//   cur_addr    - address of the byte being played
//   done        - pulse when the last byte's gap completes
module galaksija_tape_player
  import galaksija_tape_pkg::*;
#(
  parameter int unsigned ADDR_W       = 14,
  parameter int unsigned SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned LEADER_BYTES = DEF_LEADER_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              tick_en,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              tape_bit,
  output logic              active,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              done
);

  tape_state_t       state;
  logic [ADDR_W-1:0] last_q;
  logic              byte_end;
  logic              gap_end;
  logic              bg_load;
  logic              bg_clear;
  logic              in_play;
  logic              in_gap;
  logic [7:0]        bg_byte;

  assign in_gap   = (state == GAP);
  assign bg_clear = start || abort;

`ifdef TAPE_LEADER_EN
  localparam int unsigned LCNT_W = (LEADER_BYTES > 1) ? $clog2(LEADER_BYTES) : 1;

  logic [LCNT_W-1:0] leader_cnt;
  logic              in_leader;
  logic              leader_next;

  // Leader bytes are loaded straight into the bit generator as 0x00, on
  // start and at the end of each non-final leader gap.
  assign leader_next = in_gap && gap_end && in_leader && (leader_cnt != LCNT_W'(LEADER_BYTES - 1));
  assign in_play     = (state == PLAY) || (state == LEADER);
  assign bg_load     = (state == LOAD) || (start && !abort) || leader_next;
  assign bg_byte     = (state == LOAD) ? rd_data : 8'h00;
`else
  // LEADER_BYTES has no effect without the leader feature.
  if (LEADER_BYTES == 0) begin : g_leader_inert
  end
  assign in_play = (state == PLAY);
  assign bg_load = (state == LOAD);
  assign bg_byte = rd_data;
`endif

  galaksija_tape_bitgen #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) u_bitgen (
    .clk      (clk),
    .reset    (reset),
    .clear    (bg_clear),
    .load     (bg_load),
    .byte_in  (bg_byte),
    .tick_en  (tick_en),
    .play     (in_play),
    .gap      (in_gap),
    .byte_end (byte_end),
    .gap_end  (gap_end),
    .tape_bit (tape_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_q   <= '0;
      rd_addr  <= '0;
      cur_addr <= '0;
      active   <= 1'b0;
      done     <= 1'b0;
`ifdef TAPE_LEADER_EN
      leader_cnt <= '0;
      in_leader  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // cur_addr is held so the progress display stays put.
        state  <= IDLE;
        active <= 1'b0;
`ifdef TAPE_LEADER_EN
        in_leader <= 1'b0;
`endif
      end else if (start) begin
        last_q   <= last_addr;
        cur_addr <= '0;
        rd_addr  <= '0;
        active   <= 1'b1;
`ifdef TAPE_LEADER_EN
        state      <= LEADER;
        in_leader  <= 1'b1;
        leader_cnt <= '0;
`else
        state <= FETCH;
`endif
      end else begin
        case (state)
          IDLE:         state <= IDLE;
          FETCH:        state <= LOAD;
          LOAD:         state <= PLAY;
          PLAY, LEADER: if (byte_end) state <= GAP;
          GAP: begin
            if (gap_end) begin
`ifdef TAPE_LEADER_EN
              if (in_leader) begin
                if (leader_cnt == LCNT_W'(LEADER_BYTES - 1)) begin
                  in_leader <= 1'b0;
                  state     <= FETCH;
                end else begin
                  leader_cnt <= leader_cnt + 1'b1;
                  state      <= LEADER;
                end
              end else
`endif
              if (cur_addr == last_q) begin
                state  <= IDLE;
                active <= 1'b0;
                done   <= 1'b1;
              end else begin
                cur_addr <= cur_addr + 1'b1;
                rd_addr  <= cur_addr + 1'b1;
                state    <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_galaksija_tape_player.sv
// tb_galaksija_tape_player
// Self-checking bench for galaksija_tape_player with SLOT_CYCLES=4,
// GAP_CYCLES=10 (and LEADER_BYTES=2 when TAPE_LEADER_EN is defined).
module tb_galaksija_tape_player;

  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned SLOT       = 4;
  localparam int unsigned GAPC       = 10;
  localparam int unsigned LEADER     = 2;
  localparam int unsigned PLAY_TICKS = 63 * SLOT;  // 8 cells of 8 slots, last slot is the gap
  localparam int unsigned BYTE_CYC   = 2 + PLAY_TICKS + GAPC;
  localparam int unsigned MAXC       = 8192;
`ifdef TAPE_LEADER_EN
  localparam int unsigned LOFF = LEADER * (PLAY_TICKS + GAPC);
`else
  localparam int unsigned LOFF = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, start, abort, tick_en;
  logic [ADDR_W-1:0] last_addr, rd_addr, cur_addr;
  logic [7:0]        rd_data;
  logic              tape_bit, active, done;
  logic [7:0]        mem [16];

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit                ticks    [MAXC];
  bit                lvl      [MAXC];
  logic [ADDR_W-1:0] exp_addr [MAXC];

  typedef struct {
    string             name;
    logic [ADDR_W-1:0] last;
    logic [7:0]        b0, b1, b2;
    int unsigned       mode;        // 0: tick always, 1: toggle, 2: random
    int unsigned       exp_cycles;  // 0: model only
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr[3:0]];

  galaksija_tape_player #(
    .ADDR_W       (ADDR_W),
    .SLOT_CYCLES  (SLOT),
    .GAP_CYCLES   (GAPC),
    .LEADER_BYTES (LEADER)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .tick_en   (tick_en),
    .last_addr (last_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .tape_bit  (tape_bit),
    .active    (active),
    .cur_addr  (cur_addr),
    .done      (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Slot level from the tick count within a byte's bit-cell phase.
  function automatic bit cell_lvl(input int unsigned t, input logic [7:0] b);
    int unsigned si;
    si = t / SLOT;
    return !((si % 8 == 0) || ((si % 8 == 4) && b[si / 8]));
  endfunction

  task automatic emit(input int unsigned nticks, input bit data_phase, input logic [7:0] b,
                      input logic [ADDR_W-1:0] addr, inout int unsigned c);
    int unsigned t;
    t = 0;
    while (t < nticks && c < MAXC - 1) begin
      lvl[c]      = data_phase ? cell_lvl(t, b) : 1'b1;
      exp_addr[c] = addr;
      if (ticks[c]) t++;
      c++;
    end
  endtask

  // Per-cycle expectations, cycle 0 being the first cycle after start.
  task automatic build_model(input logic [ADDR_W-1:0] last, output int unsigned done_c);
    int unsigned c;
    c = 0;
`ifdef TAPE_LEADER_EN
    for (int unsigned l = 0; l < LEADER; l++) begin
      emit(PLAY_TICKS, 1'b1, 8'h00, '0, c);
      emit(GAPC, 1'b0, 8'h00, '0, c);
    end
`endif
    for (int unsigned k = 0; k <= last; k++) begin
      lvl[c] = 1'b1; exp_addr[c] = ADDR_W'(k); c++;
      lvl[c] = 1'b1; exp_addr[c] = ADDR_W'(k); c++;
      emit(PLAY_TICKS, 1'b1, mem[k], ADDR_W'(k), c);
      emit(GAPC, 1'b0, 8'h00, ADDR_W'(k), c);
    end
    exp_addr[c] = last;
    done_c = c;
  endtask

  task automatic run_trace(input string name, input logic [ADDR_W-1:0] last,
                           input int unsigned mode, input int unsigned exp_cycles);
    int unsigned done_c, n_done, bad_tape, bad_act, bad_done, bad_addr;
    int          dut_done;
    bit          exp_t;
    n_done = 0; bad_tape = 0; bad_act = 0; bad_done = 0; bad_addr = 0; dut_done = -1;
    for (int unsigned c = 0; c < MAXC; c++) begin
      case (mode)
        0:       ticks[c] = 1'b1;
        1:       ticks[c] = (c % 2 == 0);
        default: ticks[c] = ($urandom_range(0, 3) != 0);
      endcase
    end
    build_model(last, done_c);
    last_addr = last;
    start     = 1'b1;
    tick_en   = 1'b1;
    cyc();
    start     = 1'b0;
    last_addr = ADDR_W'($urandom);  // must have been sampled already
    for (int unsigned c = 0; c <= done_c; c++) begin
      exp_t = (c == 0) ? 1'b1 : lvl[c - 1];
      if (tape_bit !== exp_t) bad_tape++;
      if (active !== (c < done_c)) bad_act++;
      if (done !== (c == done_c)) bad_done++;
      if (done === 1'b1) begin
        n_done++;
        if (dut_done < 0) dut_done = int'(c);
      end
      if (rd_addr !== exp_addr[c] || cur_addr !== exp_addr[c]) bad_addr++;
      tick_en = ticks[c];
      cyc();
    end
    tick_en = 1'b1;
    check({name, " tape_bit trace errors"}, bad_tape, 0);
    check({name, " active trace errors"}, bad_act, 0);
    check({name, " done trace errors"}, bad_done, 0);
    check({name, " address trace errors"}, bad_addr, 0);
    check({name, " done pulses"}, n_done, 1);
    if (exp_cycles != 0) check({name, " cycles to done"}, dut_done, exp_cycles);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; tick_en = 1'b1; last_addr = '0;
    for (int unsigned i = 0; i < 16; i++) mem[i] = 8'($urandom);

    vecs[0] = '{"one_byte",   14'd0, 8'h01, 8'h00, 8'h00, 0, BYTE_CYC + LOFF};
    vecs[1] = '{"three_byte", 14'd2, 8'hA5, 8'h00, 8'hFF, 0, 3 * BYTE_CYC + LOFF};
    vecs[2] = '{"toggle",     14'd0, 8'h01, 8'h00, 8'h00, 1, 0};
    vecs[3] = '{"rand_two",   14'd1, 8'($urandom), 8'($urandom), 8'h00, 2, 0};
    vecs[4] = '{"rand_three", 14'd2, 8'($urandom), 8'($urandom), 8'($urandom), 2, 0};

    // Reset values
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("reset tape_bit", tape_bit, 1);
    check("reset active", active, 0);
    check("reset done", done, 0);
    check("reset rd_addr", rd_addr, 0);
    check("reset cur_addr", cur_addr, 0);

    for (int unsigned v = 0; v < 5; v++) begin
      mem[0] = vecs[v].b0; mem[1] = vecs[v].b1; mem[2] = vecs[v].b2;
      run_trace(vecs[v].name, vecs[v].last, vecs[v].mode, vecs[v].exp_cycles);
      repeat (3) cyc();
    end

    // Abort during bit 3 of byte 1, then replay from 0
    mem[0] = 8'h5A; mem[1] = 8'hC3; mem[2] = 8'h0F;
    last_addr = 14'd2; start = 1'b1; cyc(); start = 1'b0;
    repeat (BYTE_CYC + 2 + 100 + LOFF) cyc();
    check("pre-abort cur_addr", cur_addr, 1);
    check("pre-abort active", active, 1);
    abort = 1'b1; cyc(); abort = 1'b0;
    check("abort tape_bit", tape_bit, 1);
    check("abort active", active, 0);
    check("abort done", done, 0);
    check("abort cur_addr", cur_addr, 1);
    begin
      int unsigned n;
      n = 0;
      repeat (30) begin cyc(); if (done !== 1'b0 || active !== 1'b0) n++; end
      check("post-abort stays idle", n, 0);
    end
    run_trace("replay", 14'd0, 0, BYTE_CYC + LOFF);

    // Restart mid-byte 2 with a new last_addr
    last_addr = 14'd2; start = 1'b1; cyc(); start = 1'b0;
    repeat (2 * BYTE_CYC + 2 + 50 + LOFF) cyc();
    check("pre-restart cur_addr", cur_addr, 2);
    run_trace("restart", 14'd1, 0, 2 * BYTE_CYC + LOFF);

    // start and abort together: abort wins, both idle and mid-play
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    check("idle start+abort active", active, 0);
    last_addr = 14'd0; start = 1'b1; cyc(); start = 1'b0;
    repeat (20) cyc();
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    check("play start+abort active", active, 0);
    check("play start+abort tape_bit", tape_bit, 1);
    cyc(); cyc();
    check("play start+abort stays idle", active, 0);

    // Asynchronous reset mid-PLAY, inside the sync pulse of bit 1 of byte 1
    last_addr = 14'd2; start = 1'b1; cyc(); start = 1'b0;
    repeat (BYTE_CYC + 36 + LOFF) cyc();
    check("pre-reset tape_bit", tape_bit, 0);
    check("pre-reset cur_addr", cur_addr, 1);
    #2 reset = 1'b1;
    #1;
    check("async reset tape_bit", tape_bit, 1);
    check("async reset active", active, 0);
    check("async reset rd_addr", rd_addr, 0);
    check("async reset cur_addr", cur_addr, 0);
    check("async reset done", done, 0);
    cyc();
    reset = 1'b0;
    cyc();
    run_trace("after_reset", 14'd0, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
